// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX operand forwarding, immediate mux and ALU decode behind a 2-entry skid buffer
module alu_operand_stage #(
    parameter int W  = 16,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RA-1:0] in_rs_addr,
    input  logic [RA-1:0] in_rt_addr,
    input  logic [W-1:0]  in_rs_data,
    input  logic [W-1:0]  in_rt_data,
    input  logic [W-1:0]  in_imm,
    input  logic          in_alu_src,
    input  logic [1:0]    in_alu_op,
    input  logic [3:0]    in_funct,
    input  logic          exm_wr_en,
    input  logic [RA-1:0] exm_wr_addr,
    input  logic [W-1:0]  exm_wr_data,
    input  logic          wb_wr_en,
    input  logic [RA-1:0] wb_wr_addr,
    input  logic [W-1:0]  wb_wr_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_control,
    output logic          illegal_op
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   ctrl;
        logic         ill;
    } entry_t;
    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, new_e;
    logic [W-1:0] rs_fwd, rt_fwd;
    logic acc, con;
    assign rs_fwd = in_rs_addr == '0 ? '0 :
                    exm_wr_en && exm_wr_addr == in_rs_addr ? exm_wr_data :
                    wb_wr_en && wb_wr_addr == in_rs_addr ? wb_wr_data : in_rs_data;
    assign rt_fwd = in_rt_addr == '0 ? '0 :
                    exm_wr_en && exm_wr_addr == in_rt_addr ? exm_wr_data :
                    wb_wr_en && wb_wr_addr == in_rt_addr ? wb_wr_data : in_rt_data;
    assign new_e.a    = rs_fwd;
    assign new_e.b    = in_alu_src ? in_imm : rt_fwd;
    assign new_e.ctrl = in_alu_op == 2'b01 ? 3'b001 :
                        in_alu_op == 2'b11 ? 3'b100 :
                        in_alu_op == 2'b10 && in_funct <= 4'd4 ? in_funct[2:0] : 3'b000;
    assign new_e.ill  = in_alu_op == 2'b10 && in_funct > 4'd4;
    assign in_ready    = rst_n && state_q != TWO;
    assign out_valid   = state_q != EMPTY;
    assign acc         = in_valid && in_ready;
    assign con         = out_valid && out_ready;
    assign alu_a       = main_q.a;
    assign alu_b       = main_q.b;
    assign alu_control = main_q.ctrl;
    assign illegal_op  = main_q.ill;
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (acc) begin
                state_d = ONE;
                main_d  = new_e;
            end
            ONE: if (acc && con) main_d = new_e;
            else if (acc) begin
                skid_d  = new_e;
                state_d = TWO;
            end else if (con) state_d = EMPTY;
            TWO: if (con) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with a queue scoreboard checked by an independent output monitor
module tb_alu_operand_stage;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  c;
        logic        ill;
    } exp_t;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready;
    logic [2:0]  in_rs_addr = 0, in_rt_addr = 0, exm_wr_addr = 0, wb_wr_addr = 0;
    logic [15:0] in_rs_data = 0, in_rt_data = 0, in_imm = 0, exm_wr_data = 0, wb_wr_data = 0;
    logic        in_alu_src = 0, exm_wr_en = 0, wb_wr_en = 0, out_valid, out_ready = 1, illegal_op;
    logic [1:0]  in_alu_op = 0;
    logic [3:0]  in_funct = 0;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_control;
    int errors = 0, checks = 0, cyc = 0;
    exp_t sb[$];
    int pop_cyc[$];

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rs_data(in_rs_data),
        .in_rt_data(in_rt_data), .in_imm(in_imm), .in_alu_src(in_alu_src),
        .in_alu_op(in_alu_op), .in_funct(in_funct), .exm_wr_en(exm_wr_en),
        .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data), .wb_wr_en(wb_wr_en),
        .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            exp_t got, e;
            got = {alu_a, alu_b, alu_control, illegal_op};
            checks++;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got a=%h b=%h ctrl=%b ill=%b", alu_a, alu_b, alu_control, illegal_op);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL entry got a=%h b=%h ctrl=%b ill=%b expected a=%h b=%h ctrl=%b ill=%b",
                             got.a, got.b, got.c, got.ill, e.a, e.b, e.c, e.ill);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic set_in(input logic [2:0] rsa, input logic [15:0] rsd, input logic [2:0] rta,
                          input logic [15:0] rtd, input logic [15:0] imm, input logic src,
                          input logic [1:0] op, input logic [3:0] fn);
        in_rs_addr = rsa; in_rs_data = rsd; in_rt_addr = rta; in_rt_data = rtd;
        in_imm = imm; in_alu_src = src; in_alu_op = op; in_funct = fn;
    endtask

    task automatic send(input logic [2:0] rsa, input logic [15:0] rsd, input logic [2:0] rta,
                        input logic [15:0] rtd, input logic [15:0] imm, input logic src,
                        input logic [1:0] op, input logic [3:0] fn, input exp_t e);
        int n = 0;
        set_in(rsa, rsd, rta, rtd, imm, src, op, fn);
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b expected 1", in_ready);
        end else sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic fwd(input logic ee, input logic [2:0] ea, input logic [15:0] ed,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd);
        exm_wr_en = ee; exm_wr_addr = ea; exm_wr_data = ed;
        wb_wr_en = we; wb_wr_addr = wa; wb_wr_data = wd;
    endtask

    initial begin
        int base;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_alu_control", {13'd0, alu_control}, 16'd0);
        check("rst_alu_a", alu_a, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("release_in_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk);
        #1;
        send(3'd1, 16'h00F0, 3'd2, 16'h0F0F, 16'h0, 0, 2'b10, 4'b0010, '{16'h00F0, 16'h0F0F, 3'b010, 1'b0});
        fwd(1, 3'd3, 16'h1111, 1, 3'd3, 16'h2222);
        send(3'd3, 16'h0333, 3'd0, 16'h5555, 16'h0, 0, 2'b00, 4'b0, '{16'h1111, 16'h0000, 3'b000, 1'b0});
        fwd(1, 3'd5, 16'h1111, 1, 3'd3, 16'h2222);
        send(3'd3, 16'h0333, 3'd0, 16'h5555, 16'h0, 0, 2'b00, 4'b0, '{16'h2222, 16'h0000, 3'b000, 1'b0});
        fwd(1, 3'd0, 16'h7777, 0, 3'd0, 16'h0);
        send(3'd0, 16'hABCD, 3'd4, 16'h0044, 16'h0, 0, 2'b01, 4'b0, '{16'h0000, 16'h0044, 3'b001, 1'b0});
        fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        send(3'd5, 16'h0005, 3'd6, 16'h1234, 16'hFFFC, 1, 2'b00, 4'b0, '{16'h0005, 16'hFFFC, 3'b000, 1'b0});
        send(3'd6, 16'h0006, 3'd7, 16'h0007, 16'h0, 0, 2'b10, 4'b1111, '{16'h0006, 16'h0007, 3'b000, 1'b1});
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        fwd(1, 3'd6, 16'h6666, 1, 3'd2, 16'h3333);
        send(3'd1, 16'h0010, 3'd2, 16'h0002, 16'h0, 0, 2'b11, 4'b0, '{16'h0010, 16'h3333, 3'b100, 1'b0});
        send(3'd3, 16'h0030, 3'd4, 16'h0040, 16'h0, 0, 2'b10, 4'b0011, '{16'h0030, 16'h0040, 3'b011, 1'b0});
        set_in(3'd5, 16'h0050, 3'd6, 16'h0060, 16'h0, 0, 2'b10, 4'b0001);
        in_valid = 1;
        @(negedge clk);
        check("two_in_ready", {15'd0, in_ready}, 16'd0);
        check("two_out_valid", {15'd0, out_valid}, 16'd1);
        @(posedge clk);
        #1 out_ready = 1;
        base = pop_cyc.size();
        send(3'd5, 16'h0050, 3'd6, 16'h0060, 16'h0, 0, 2'b10, 4'b0001, '{16'h0050, 16'h6666, 3'b001, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        if (pop_cyc.size() < base + 3) check("drain_count", 16'(pop_cyc.size() - base), 16'd3);
        else check("zero_bubble_span", 16'(pop_cyc[base + 2] - pop_cyc[base]), 16'd2);
        out_ready = 0;
        fwd(0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
        send(3'd1, 16'h0101, 3'd0, 16'h0, 16'h0, 0, 2'b10, 4'b0100, '{16'h0101, 16'h0000, 3'b100, 1'b0});
        send(3'd2, 16'h0202, 3'd0, 16'h0, 16'h0, 0, 2'b00, 4'b0, '{16'h0202, 16'h0000, 3'b000, 1'b0});
        set_in(3'd3, 16'hDEAD, 3'd0, 16'h0, 16'h0, 0, 2'b00, 4'b0);
        in_valid = 1;
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        in_valid = 0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", {15'd0, out_valid}, 16'd0);
        @(posedge clk);
        #1 out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        send(3'd4, 16'h0404, 3'd5, 16'h0505, 16'h0, 0, 2'b01, 4'b0, '{16'h0404, 16'h0505, 3'b001, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
